func_stream_ctrl: RTL and testbench



---
 rtl/func_ctrl_pkg.sv | 19 +
 rtl/func_credit_cnt.sv | 42 ++++
 rtl/func_stream_ctrl.sv | 148 ++++++++++++++
 tb/tb_func_stream_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/func_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : func_ctrl_pkg
// Brief  : Shared run-controller state type and default counter width.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package func_ctrl_pkg;

  localparam int C_DEF_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage : func_ctrl_pkg
`default_nettype wire

// File: rtl/func_credit_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : func_credit_cnt
// Brief  : Up/down occupancy counter with an at-limit flag.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module func_credit_cnt #(
  parameter int C_MAX = 16,
  parameter int C_W   = $clog2(C_MAX + 1)
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           clr,
  input  logic           inc,
  input  logic           dec,
  output logic [C_W-1:0] count,
  output logic           at_max
);

  localparam logic [C_W-1:0] C_MAX_V = C_W'(C_MAX);
  localparam logic [C_W-1:0] C_ONE   = C_W'(1);

  logic [C_W-1:0] r_count;

  // Simultaneous inc and dec cancel, so the count may sit at C_MAX-1 with both.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !dec) begin
      r_count <= r_count + C_ONE;
    end else if (dec && !inc) begin
      r_count <= r_count - C_ONE;
    end
  end

  assign count  = r_count;
  assign at_max = (r_count == C_MAX_V);

endmodule : func_credit_cnt
`default_nettype wire

// File: rtl/func_stream_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : func_stream_ctrl
// Brief  : Joins AXI input handshakes into the kernel, limits in-flight words
//          and counts a programmed run length to a one-cycle done pulse.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module func_stream_ctrl
  import func_ctrl_pkg::*;
#(
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_CNT_WIDTH    = C_DEF_CNT_WIDTH,
  parameter int C_MAX_INFLIGHT = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      ctrl_start,
  input  logic [C_CNT_WIDTH-1:0]    ctrl_len,
  output logic                      ctrl_busy,
  output logic                      ctrl_done,
  output logic [C_CNT_WIDTH-1:0]    in_count,
  output logic [C_CNT_WIDTH-1:0]    out_count,
  input  logic [C_NUM_CHANNELS-1:0] s_tvalid,
  output logic [C_NUM_CHANNELS-1:0] s_tready,
  output logic                      k_ivalid,
  input  logic                      k_iready,
  input  logic                      k_ovalid,
  output logic                      k_oready,
  output logic                      m_tvalid,
  input  logic                      m_tready
);

  localparam int                     C_CREDIT_W = $clog2(C_MAX_INFLIGHT + 1);
  localparam logic [C_CNT_WIDTH-1:0] C_CNT_ONE  = C_CNT_WIDTH'(1);

  ctrl_state_t              r_state;
  ctrl_state_t              w_state_nxt;
  logic [C_CNT_WIDTH-1:0]   r_len_q;
  logic [C_CNT_WIDTH-1:0]   r_in_cnt;
  logic [C_CNT_WIDTH-1:0]   r_out_cnt;
  logic [C_CREDIT_W-1:0]    w_inflight;
  logic                     w_at_max;
  logic                     w_start_run;
  logic                     w_in_open;
  logic                     w_out_open;
  logic                     w_join;
  logic                     w_fire_in;
  logic                     w_fire_out;
  logic                     w_last_in;
  logic                     w_last_out;

  assign w_start_run = (r_state == IDLE) && ctrl_start && (ctrl_len != '0);

  // Handshake join: every channel must be valid before any beat is taken.
  assign w_in_open  = (r_state == RUN) && (r_in_cnt < r_len_q);
  assign w_join     = w_in_open && !w_at_max && (&s_tvalid);
  assign k_ivalid   = w_join;
  assign s_tready   = {C_NUM_CHANNELS{w_join & k_iready}};
  assign w_fire_in  = w_join & k_iready;

  assign w_out_open = ((r_state == RUN) || (r_state == DRAIN)) && (r_out_cnt < r_len_q);
  assign m_tvalid   = k_ovalid & w_out_open;
  assign k_oready   = m_tready & w_out_open;
  assign w_fire_out = k_ovalid & k_oready;

  assign w_last_in  = w_fire_in  && ((r_in_cnt  + C_CNT_ONE) == r_len_q);
  assign w_last_out = w_fire_out && ((r_out_cnt + C_CNT_ONE) == r_len_q);

  func_credit_cnt #(
    .C_MAX (C_MAX_INFLIGHT),
    .C_W   (C_CREDIT_W)
  ) u_credit (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (w_start_run),
    .inc     (w_fire_in),
    .dec     (w_fire_out),
    .count   (w_inflight),
    .at_max  (w_at_max)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (ctrl_start) begin
          w_state_nxt = (ctrl_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_last_in) begin
          w_state_nxt = w_last_out ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (w_last_out) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctrl_busy = (r_state != IDLE);
    ctrl_done = (r_state == DONE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_len_q   <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_start_run) begin
      r_len_q   <= ctrl_len;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_fire_in) begin
        r_in_cnt <= r_in_cnt + C_CNT_ONE;
      end
      if (w_fire_out) begin
        r_out_cnt <= r_out_cnt + C_CNT_ONE;
      end
    end
  end

  assign in_count  = r_in_cnt;
  assign out_count = r_out_cnt;

  // Kernel offering data after the run has already emitted len_q words.
  a_no_excess_out: assert property (@(posedge aclk) disable iff (!aresetn)
    !(k_ovalid && (r_state != IDLE) && (r_out_cnt == r_len_q)));

  a_credit_bound: assert property (@(posedge aclk) disable iff (!aresetn)
    w_inflight <= C_CREDIT_W'(C_MAX_INFLIGHT));

endmodule : func_stream_ctrl
`default_nettype wire

// File: tb/tb_func_stream_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_func_stream_ctrl
// Brief  : Randomised scoreboard bench with a run-level reference model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_func_stream_ctrl;

  localparam int NCH  = 2;
  localparam int CW   = 32;
  localparam int MAXI = 4;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic           ctrl_start = 1'b0;
  logic [CW-1:0]  ctrl_len = '0;
  logic           ctrl_busy, ctrl_done;
  logic [CW-1:0]  in_count, out_count;
  logic [NCH-1:0] s_tvalid = '0;
  logic [NCH-1:0] s_tready;
  logic           k_ivalid, k_oready, m_tvalid;
  logic           k_iready = 1'b0;
  logic           k_ovalid = 1'b0;
  logic           m_tready = 1'b0;

  func_stream_ctrl #(
    .C_NUM_CHANNELS (NCH),
    .C_CNT_WIDTH    (CW),
    .C_MAX_INFLIGHT (MAXI)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .ctrl_start (ctrl_start),
    .ctrl_len   (ctrl_len),
    .ctrl_busy  (ctrl_busy),
    .ctrl_done  (ctrl_done),
    .in_count   (in_count),
    .out_count  (out_count),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .k_ivalid   (k_ivalid),
    .k_iready   (k_iready),
    .k_ovalid   (k_ovalid),
    .k_oready   (k_oready),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Kernel stand-in: release cycle of each word it holds.
  int kq[$];
  int lat = 5;

  // Run-level reference: 0 idle, 1 active, 2 completion cycle.
  int m_phase = 0;
  int m_len   = 0;
  int m_win   = 0;
  int m_wout  = 0;
  int sb[$];

  int sv_pct = 100, kir_pct = 100, mtr_pct = 100, bs_pct = 0;
  int sv_force = -1, mtr_force = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit start, input int len);
    bit             act, exp_kiv, exp_oo, fi, fo;
    logic [NCH-1:0] exp_str;
    @(negedge aclk);
    ctrl_start = start;
    ctrl_len   = CW'(len);
    if (sv_force >= 0) s_tvalid = 2'(sv_force);
    else s_tvalid = ($urandom_range(99) < sv_pct) ? 2'b11 : 2'($urandom);
    k_iready = ($urandom_range(99) < kir_pct);
    if (mtr_force >= 0) m_tready = mtr_force[0];
    else m_tready = ($urandom_range(99) < mtr_pct);
    k_ovalid = (kq.size() > 0) && (kq[0] <= cyc);
    #1;
    act     = (m_phase == 1);
    exp_kiv = act && (m_win < m_len) && ((m_win - m_wout) < MAXI) && (&s_tvalid);
    exp_oo  = act && (m_wout < m_len);
    exp_str = {NCH{exp_kiv & k_iready}};
    chk("k_ivalid",  k_ivalid,  exp_kiv);
    chk("s_tready",  s_tready,  exp_str);
    chk("m_tvalid",  m_tvalid,  k_ovalid & exp_oo);
    chk("k_oready",  k_oready,  m_tready & exp_oo);
    chk("busy",      ctrl_busy, m_phase != 0);
    chk("in_count",  in_count,  m_win);
    chk("out_count", out_count, m_wout);
    fi = exp_kiv & k_iready;
    fo = k_ovalid & m_tready & exp_oo;
    if (k_ivalid && k_iready) kq.push_back(cyc + lat);
    if (k_ovalid && k_oready && kq.size() > 0) void'(kq.pop_front());
    #2;
    if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 0 && start) begin
      if (len == 0) begin
        m_phase = 2;
        sb.push_back(m_win);
      end else begin
        m_phase = 1; m_len = len; m_win = 0; m_wout = 0;
        sb.push_back(len);
      end
    end else if (m_phase == 1) begin
      m_win  += int'(fi);
      m_wout += int'(fo);
      if (m_wout == m_len) m_phase = 2;
    end
  endtask

  task automatic run(input int len, input int budget);
    int n = 0;
    step(1'b1, len);
    while (m_phase != 0 && n < budget) begin
      step($urandom_range(99) < bs_pct, $urandom_range(0, 20));
      n++;
    end
    if (m_phase != 0) chk("run_timeout", 1, 0);
  endtask

  task automatic nominal_cfg();
    sv_force = 3; mtr_force = 1; kir_pct = 100; lat = 5; bs_pct = 0;
  endtask

  // Completion monitor: a done pulse must retire exactly one queued run.
  initial begin
    int e;
    forever begin
      @(negedge aclk);
      #2;
      if (aresetn && (ctrl_done || m_phase == 2)) begin
        chk("done_pulse", ctrl_done, m_phase == 2);
        if (ctrl_done) begin
          if (sb.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("done_in_count",  in_count,  e);
            chk("done_out_count", out_count, e);
          end
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_busy", ctrl_busy, 0);
    chk("rst_done", ctrl_done, 0);
    chk("rst_in",   in_count,  0);
    chk("rst_out",  out_count, 0);
    chk("rst_kiv",  k_ivalid,  0);
    chk("rst_mtv",  m_tvalid,  0);
    @(negedge aclk);
    aresetn = 1'b1;

    nominal_cfg();
    run(8, 200);

    // Channel skew: only channel 0 valid for three cycles.
    sv_force = 1;
    step(1'b1, 6);
    repeat (3) step(1'b0, 0);
    chk("skew_in_cnt", in_count, 0);
    sv_force = 3;
    n = 0;
    while (m_phase != 0 && n < 200) begin step(1'b0, 0); n++; end
    if (m_phase != 0) chk("skew_timeout", 1, 0);

    // Credit exhaustion with the output side blocked.
    mtr_force = 0;
    step(1'b1, 10);
    repeat (20) step(1'b0, 0);
    chk("credit_in_cnt", in_count, MAXI);
    chk("credit_kiv", k_ivalid, 0);
    mtr_force = 1;
    n = 0;
    while (m_phase != 0 && n < 200) begin step(1'b0, 0); n++; end
    if (m_phase != 0) chk("credit_timeout", 1, 0);

    run(0, 10);

    // Start pulses while busy must not disturb the run.
    step(1'b1, 7);
    repeat (3) step(1'b1, 3);
    n = 0;
    while (m_phase != 0 && n < 200) begin step(1'b0, 0); n++; end
    if (m_phase != 0) chk("busy_timeout", 1, 0);

    for (int r = 0; r < 30; r++) begin
      sv_force = -1; mtr_force = -1;
      sv_pct  = $urandom_range(50, 100);
      kir_pct = $urandom_range(40, 100);
      mtr_pct = $urandom_range(30, 100);
      lat     = $urandom_range(1, 6);
      bs_pct  = 10;
      run($urandom_range(1, 20), 600);
      repeat ($urandom_range(0, 2)) step(1'b0, 0);
    end

    // Asynchronous reset mid-run, then a fresh short run.
    nominal_cfg();
    kir_pct = 100;
    step(1'b1, 8);
    n = 0;
    while (m_win < 5 && n < 100) begin step(1'b0, 0); n++; end
    @(posedge aclk);
    #2;
    chk("pre_rst_in", in_count, 5);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_busy", ctrl_busy, 0);
    chk("mid_rst_in",   in_count,  0);
    chk("mid_rst_out",  out_count, 0);
    chk("mid_rst_kiv",  k_ivalid,  0);
    chk("mid_rst_str",  s_tready,  0);
    chk("mid_rst_kor",  k_oready,  0);
    kq.delete(); sb.delete();
    m_phase = 0; m_len = 0; m_win = 0; m_wout = 0;
    k_ovalid = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    run(3, 100);
    repeat (2) step(1'b0, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_func_stream_ctrl
`default_nettype wire
